insn_decode: RTL and testbench
==============================

Name: insn_decode

Overview:
- Registered RV32I instruction decoder for the rv32i core's decode stage.
- Splits a 32-bit instruction word into opcode, funct, register and immediate fields.
- Produces a sign-extended immediate for each instruction format and flags instructions outside RV32I base + Zicsr + FENCE.
- Outputs are registered with one-cycle latency, gated by an enable.

Parameters:
- None.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  capture enable; when high, decoded insn is registered
- insn  input  32  instruction word
- opcode  output  5  insn[6:2]
- funct7  output  7  insn[31:25], raw
- funct3  output  3  insn[14:12], raw
- invalid  output  1  instruction is illegal or unsupported
- rd  output  5  insn[11:7], raw
- rs1  output  5  insn[19:15], raw
- rs2  output  5  insn[24:20], raw
- imm  output  32  sign-extended immediate for the instruction's format

Behaviour:
- All outputs are registers; rst has priority over en.
- Reset value: every output is 0 (invalid=0, imm=0).
- On a clk edge with rst=0 and en=1, outputs take the decode of the current insn (one-cycle latency).
- With en=0, outputs hold their values.
- Field outputs opcode, funct7, funct3, rd, rs1, rs2 are always the raw bit slices, regardless of format or validity.
- Opcode codes (insn[6:2]):
  - LOAD=00000, MISC=00011, ALUIMM=00100, AUIPC=00101
  - STORE=01000, ALU=01100, LUI=01101
  - BRANCH=11000, JALR=11001, JAL=11011, SYSTEM=11100
- imm by opcode:
  - I-type, for LOAD, ALUIMM, JALR, SYSTEM, MISC: sext(insn[31:20]).
  - S-type, for STORE: sext({insn[31:25],insn[11:7]}).
  - B-type, for BRANCH: sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}).
  - U-type, for LUI, AUIPC: {insn[31:12],12'b0}.
  - J-type, for JAL: sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}).
  - ALU (R-type) and invalid opcodes: 0.
  - For SYSTEM, imm[11:0] equals the CSR address.
- invalid=1 if any of the following holds:
  - insn[1:0]!=2'b11.
  - Opcode not in the list above.
  - ALU: funct7 not 0000000, or not 0100000 with funct3 in {000,101}.
  - ALUIMM, funct3=001: funct7 must be 0000000.
  - ALUIMM, funct3=101: funct7 must be 0000000 or 0100000.
  - BRANCH: funct3 is 010 or 011.
  - LOAD: funct3 is 011, 110 or 111.
  - STORE: funct3 >= 011.
  - JALR: funct3 != 000.
  - MISC: funct3 not 000 or 001.
  - SYSTEM: funct3=100.
  - SYSTEM, funct3=000: insn[31:20] not one of 000, 001, 002, 102, 302, 105 (hex), or rs1/rd nonzero.
- When invalid=1, field outputs still carry the raw slices; imm follows the opcode rule, or 0 if the opcode is unknown.
- Reset asserted while en=1: reset wins, outputs are 0.
- Purely combinational decode internally; no other state.

Test Plan:
- Reset: rst=1 for 2 cycles with insn=0xFFDFF0EF, en=1 -> all outputs 0; next cycle after rst=0 they reflect insn.
- addi x1,x0,5 (0x00500093): opcode=00100, rd=1, rs1=0, funct3=0, imm=5, invalid=0.
- lui x2,0x12345 (0x12345137): opcode=01101, rd=2, imm=0x12345000.
- jal x1,-4 (0xFFDFF0EF): opcode=11011, rd=1, imm=0xFFFFFFFC.
- beq x1,x2,+8 (0x00208463): opcode=11000, rs1=1, rs2=2, imm=8.
- sw x2,-4(x1) (0xFE20AE23): opcode=01000, funct3=010, imm=0xFFFFFFFC.
- Illegal cases, each -> invalid=1:
  - 0x00000000 (insn[1:0]=00).
  - 0x40209033 (ALU funct7=0100000 with funct3=001).
  - Toggle en=0: outputs hold the previous decode while insn changes.

Source files
------------

// File: rtl/insn_decode_if.sv
// Decode-stage bus: instruction word and capture enable in, registered fields out.
interface insn_decode_if;
    logic        en;
    logic [31:0] insn;
    logic [4:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    modport master (
        output en, insn,
        input  opcode, funct7, funct3, invalid, rd, rs1, rs2, imm
    );

    modport slave (
        input  en, insn,
        output opcode, funct7, funct3, invalid, rd, rs1, rs2, imm
    );
endinterface

// File: rtl/insn_decode.sv
// Registered RV32I (+Zicsr, FENCE) decoder: raw field slices, per-format
// sign-extended immediate and an illegal-instruction flag, one-cycle latency.
module insn_decode (
    input  logic         clk,
    input  logic         rst,
    insn_decode_if.slave dec
);
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_MISC   = 5'b00011;
    localparam logic [4:0] OP_ALUIMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALU    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    logic [31:0] insn;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm_d;
    logic        inv_d;

    assign insn = dec.insn;
    assign op   = insn[6:2];
    assign f3   = insn[14:12];
    assign f7   = insn[31:25];

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    // Select the immediate format and judge legality from opcode/funct fields.
    always_comb begin
        imm_d = '0;
        inv_d = 1'b0;
        case (op)
            OP_LOAD: begin
                imm_d = imm_i;
                inv_d = f3 inside {3'b011, 3'b110, 3'b111};
            end
            OP_MISC: begin
                imm_d = imm_i;
                inv_d = !(f3 inside {3'b000, 3'b001});
            end
            OP_ALUIMM: begin
                imm_d = imm_i;
                if (f3 == 3'b001)
                    inv_d = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    inv_d = !(f7 inside {7'b0000000, 7'b0100000});
            end
            OP_AUIPC, OP_LUI: imm_d = imm_u;
            OP_STORE: begin
                imm_d = imm_s;
                inv_d = (f3 >= 3'b011);
            end
            OP_ALU: begin
                // Only the SUB/SRA encodings may set funct7[5]; M-extension is rejected.
                inv_d = !((f7 == 7'b0000000) ||
                          (f7 == 7'b0100000 && (f3 inside {3'b000, 3'b101})));
            end
            OP_BRANCH: begin
                imm_d = imm_b;
                inv_d = f3 inside {3'b010, 3'b011};
            end
            OP_JALR: begin
                imm_d = imm_i;
                inv_d = (f3 != 3'b000);
            end
            OP_JAL: imm_d = imm_j;
            OP_SYSTEM: begin
                imm_d = imm_i;
                if (f3 == 3'b100)
                    inv_d = 1'b1;
                else if (f3 == 3'b000)
                    // ECALL, EBREAK, URET, SRET, MRET, WFI only, with rs1/rd zero.
                    inv_d = !(insn[31:20] inside {12'h000, 12'h001, 12'h002,
                                                  12'h102, 12'h302, 12'h105}) ||
                            (insn[19:15] != 5'd0) || (insn[11:7] != 5'd0);
            end
            default: inv_d = 1'b1;
        endcase
        if (insn[1:0] != 2'b11)
            inv_d = 1'b1;
    end

    // Output register: reset clears everything, otherwise capture on enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec.opcode  <= '0;
            dec.funct7  <= '0;
            dec.funct3  <= '0;
            dec.invalid <= 1'b0;
            dec.rd      <= '0;
            dec.rs1     <= '0;
            dec.rs2     <= '0;
            dec.imm     <= '0;
        end else if (dec.en) begin
            dec.opcode  <= op;
            dec.funct7  <= f7;
            dec.funct3  <= f3;
            dec.invalid <= inv_d;
            dec.rd      <= insn[11:7];
            dec.rs1     <= insn[19:15];
            dec.rs2     <= insn[24:20];
            dec.imm     <= imm_d;
        end
    end
endmodule

// File: tb/tb_insn_decode.sv
// Self-checking bench for insn_decode: randomized instructions against a
// table-driven reference decoder, plus literal expectations from known encodings.
module tb_insn_decode;
    typedef struct packed {
        logic [4:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        inv;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    logic clk = 1'b0;
    logic rst;
    insn_decode_if dec ();

    insn_decode dut (
        .clk (clk),
        .rst (rst),
        .dec (dec)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference decoder: immediates built with signed arithmetic, legality from
    // a per-opcode table of allowed funct values.
    function automatic dec_t model(input logic [31:0] w);
        dec_t d;
        int s, hi;
        logic [4:0] o;
        logic [2:0] f3;
        logic [6:0] f7;
        logic known;
        s  = int'(w);
        hi = s >>> 31;
        o  = w[6:2];
        f3 = w[14:12];
        f7 = w[31:25];
        d.op = o; d.f7 = f7; d.f3 = f3;
        d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = 32'd0;
        d.inv = 1'b0;
        known = 1'b1;
        case (o)
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: d.imm = 32'(s >>> 20);
            5'b01000: d.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
            5'b11000: d.imm = 32'(hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            5'b00101, 5'b01101: d.imm = w & 32'hFFFF_F000;
            5'b11011: d.imm = 32'(hi * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            5'b01100: d.imm = 32'd0;
            default: known = 1'b0;
        endcase
        if (!known || w[1:0] != 2'b11) d.inv = 1'b1;
        case (o)
            5'b00000: if (f3 inside {3, 6, 7}) d.inv = 1'b1;
            5'b00011: if (f3 > 1) d.inv = 1'b1;
            5'b00100: begin
                if (f3 == 1 && f7 != 0) d.inv = 1'b1;
                if (f3 == 5 && f7 != 0 && f7 != 7'h20) d.inv = 1'b1;
            end
            5'b01000: if (f3 > 2) d.inv = 1'b1;
            5'b01100: if (!(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) d.inv = 1'b1;
            5'b11000: if (f3 == 2 || f3 == 3) d.inv = 1'b1;
            5'b11001: if (f3 != 0) d.inv = 1'b1;
            5'b11100: begin
                if (f3 == 4) d.inv = 1'b1;
                if (f3 == 0 && (!(w[31:20] inside {12'h000, 12'h001, 12'h002, 12'h102, 12'h302, 12'h105})
                                || w[19:15] != 0 || w[11:7] != 0)) d.inv = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

    dec_t exp_q;
    bit   started = 1'b0;

    // Expected output register, advanced by the same clock the DUT sees.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_q   = '0;
            started = 1'b1;
        end else if (dec.en === 1'b1) begin
            exp_q = model(dec.insn);
        end
    end

    // Literal expectations handed over from the stimulus process.
    int          lit_id = 0;
    int          lit_seen = 0;
    string       lit_name;
    logic [4:0]  lit_op;
    logic [4:0]  lit_rd;
    logic [31:0] lit_imm;
    logic        lit_inv;

    function automatic dec_t dut_out();
        dec_t d;
        d.op = dec.opcode; d.f7 = dec.funct7; d.f3 = dec.funct3; d.inv = dec.invalid;
        d.rd = dec.rd; d.rs1 = dec.rs1; d.rs2 = dec.rs2; d.imm = dec.imm;
        return d;
    endfunction

    // Single compare process: model check every cycle, literal check when posted.
    always @(negedge clk) begin
        dec_t a;
        a = dut_out();
        if (started) begin
            total++;
            if (a === exp_q) passed++;
            else $display("FAIL model t=%0t insn=%h got=%h want=%h", $time, dec.insn, a, exp_q);
        end
        if (lit_id != lit_seen) begin
            lit_seen = lit_id;
            total++;
            if (a.op === lit_op && a.rd === lit_rd && a.imm === lit_imm && a.inv === lit_inv)
                passed++;
            else
                $display("FAIL %s got op=%b rd=%0d imm=%h inv=%b want op=%b rd=%0d imm=%h inv=%b",
                         lit_name, a.op, a.rd, a.imm, a.inv, lit_op, lit_rd, lit_imm, lit_inv);
        end
    end

    task automatic post(input string n, input logic [4:0] op, input logic [4:0] rdv,
                        input logic [31:0] immv, input logic invv);
        @(posedge clk); #1;
        lit_name = n; lit_op = op; lit_rd = rdv; lit_imm = immv; lit_inv = invv;
        lit_id++;
    endtask

    task automatic lit(input string n, input logic [31:0] w, input logic [4:0] op,
                       input logic [4:0] rdv, input logic [31:0] immv, input logic invv);
        @(posedge clk); #2;
        dec.insn = w; dec.en = 1'b1;
        post(n, op, rdv, immv, invv);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                 5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
        logic [11:0] csrs [6] = '{12'h000, 12'h001, 12'h002, 12'h102, 12'h302, 12'h105};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) return w;
        w[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
        w[6:2] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 1) == 0) w[11:7]  = 5'd0;
        if (w[6:2] == 5'b11100 && $urandom_range(0, 1) == 0) begin
            w[31:20] = csrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) w[14:12] = 3'b000;
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        dec.en = 1'b1;
        dec.insn = 32'hFFDF_F0EF;
        // Reset held two cycles with a valid jal presented: outputs stay zero.
        post("reset_1", 5'd0, 5'd0, 32'd0, 1'b0);
        post("reset_2", 5'd0, 5'd0, 32'd0, 1'b0);
        #1 rst = 1'b0;
        post("after_reset_jal", 5'b11011, 5'd1, 32'hFFFF_FFFC, 1'b0);

        lit("addi",      32'h0050_0093, 5'b00100, 5'd1,  32'd5,         1'b0);
        lit("lui",       32'h1234_5137, 5'b01101, 5'd2,  32'h1234_5000, 1'b0);
        lit("jal",       32'hFFDF_F0EF, 5'b11011, 5'd1,  32'hFFFF_FFFC, 1'b0);
        lit("beq",       32'h0020_8463, 5'b11000, 5'd8,  32'd8,         1'b0);
        lit("sw",        32'hFE20_AE23, 5'b01000, 5'd28, 32'hFFFF_FFFC, 1'b0);
        lit("ill_zero",  32'h0000_0000, 5'b00000, 5'd0,  32'd0,         1'b1);
        lit("ill_alu",   32'h4020_9033, 5'b01100, 5'd0,  32'd0,         1'b1);
        lit("mret",      32'h3020_0073, 5'b11100, 5'd0,  32'h0000_0302, 1'b0);
        lit("ecall_rd",  32'h0000_00F3, 5'b11100, 5'd1,  32'd0,         1'b1);
        lit("sltiu_neg", 32'hFFF0_3093, 5'b00100, 5'd1,  32'hFFFF_FFFF, 1'b0);

        // Enable low: outputs keep the last decode while insn changes.
        @(posedge clk); #2;
        dec.en = 1'b0; dec.insn = 32'h0050_0093;
        post("hold_1", 5'b00100, 5'd1, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #2;
        dec.insn = 32'h1234_5137;
        post("hold_2", 5'b00100, 5'd1, 32'hFFFF_FFFF, 1'b0);

        // Reset while enabled wins over capture.
        @(posedge clk); #2;
        dec.en = 1'b1; rst = 1'b1;
        post("rst_over_en", 5'd0, 5'd0, 32'd0, 1'b0);
        #1 rst = 1'b0;

        repeat (3000) begin
            @(posedge clk); #2;
            dec.insn = rand_insn();
            dec.en   = ($urandom_range(0, 4) != 0);
            rst      = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
